// File: rtl/dual_port_bram_be.sv
// True dual-port block RAM with byte-lane writes, per-port read-during-write modes,
// a 1- or 2-stage read pipeline, write-write collision arbitration and post-reset array clear.
module dual_port_bram_be #(
    parameter int unsigned DWIDTH        = 32,
    parameter int unsigned BYTE_W        = 8,
    parameter int unsigned DEPTH         = 1024,
    parameter int unsigned ADDR_W        = $clog2(DEPTH),
    parameter int unsigned READ_LATENCY  = 1,
    parameter int unsigned RDW_MODE_0    = 1,
    parameter int unsigned RDW_MODE_1    = 1,
    parameter int unsigned COLL_PRIORITY = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clk_en,
    input  logic                     port_en_0,
    input  logic                     port_en_1,
    input  logic [DWIDTH/BYTE_W-1:0] wr_be_0,
    input  logic [DWIDTH/BYTE_W-1:0] wr_be_1,
    input  logic [ADDR_W-1:0]        addr_in_0,
    input  logic [ADDR_W-1:0]        addr_in_1,
    input  logic [DWIDTH-1:0]        data_in_0,
    input  logic [DWIDTH-1:0]        data_in_1,
    output logic [DWIDTH-1:0]        data_out_0,
    output logic [DWIDTH-1:0]        data_out_1,
    output logic                     dout_valid_0,
    output logic                     dout_valid_1,
    output logic                     init_busy,
    output logic                     collision_flag,
    output logic [15:0]              collision_count
);
    localparam int unsigned NBE = DWIDTH / BYTE_W;

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_READY = 1'b1;

    logic [DWIDTH-1:0] mem_q [DEPTH];

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              flag_q;
    logic [15:0]       cnt_q;

    logic              ready, same, coll;
    logic              acc0, acc1, wr0, wr1;
    logic [DWIDTH-1:0] old0, old1, fin0, fin1;
    logic [DWIDTH-1:0] rd [2];
    logic [1:0]        upd;

    // Lanes the other port also enables go to the other port only when it has priority.
    function automatic logic [DWIDTH-1:0] merge(
        input logic [NBE-1:0]    own_be,
        input logic [NBE-1:0]    oth_be,
        input logic [DWIDTH-1:0] own_d,
        input logic [DWIDTH-1:0] oth_d,
        input logic [DWIDTH-1:0] old_d,
        input logic              oth_wins
    );
        logic [DWIDTH-1:0] w;
        w = old_d;
        for (int unsigned b = 0; b < NBE; b++) begin
            if (oth_be[b] && (oth_wins || !own_be[b]))
                w[b*BYTE_W +: BYTE_W] = oth_d[b*BYTE_W +: BYTE_W];
            else if (own_be[b])
                w[b*BYTE_W +: BYTE_W] = own_d[b*BYTE_W +: BYTE_W];
        end
        return w;
    endfunction

    always_comb begin
        ready = (state_q == S_READY);
        acc0  = ready && clk_en && port_en_0;
        acc1  = ready && clk_en && port_en_1;
        wr0   = acc0 && (|wr_be_0);
        wr1   = acc1 && (|wr_be_1);
        same  = acc0 && acc1 && (addr_in_0 == addr_in_1);
        coll  = same && (wr0 || wr1);
        old0  = mem_q[addr_in_0];
        old1  = mem_q[addr_in_1];
        fin0  = merge(wr_be_0, same ? wr_be_1 : '0, data_in_0, data_in_1, old0, COLL_PRIORITY == 1);
        fin1  = merge(wr_be_1, same ? wr_be_0 : '0, data_in_1, data_in_0, old1, COLL_PRIORITY == 0);
        // A reading port never sets wr, so it always sees the pre-write word.
        rd[0]  = (wr0 && RDW_MODE_0 == 1) ? fin0 : old0;
        rd[1]  = (wr1 && RDW_MODE_1 == 1) ? fin1 : old1;
        upd[0] = acc0 && !(wr0 && RDW_MODE_0 == 2);
        upd[1] = acc1 && !(wr1 && RDW_MODE_1 == 2);
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (!ready) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                state_d = S_READY;
                ptr_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!ready) begin
                mem_q[ptr_q] <= '0;
            end else begin
                if (wr0) mem_q[addr_in_0] <= fin0;
                if (wr1) mem_q[addr_in_1] <= fin1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CLEAR;
            ptr_q   <= '0;
            flag_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            flag_q  <= coll;
            if (coll && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 1'b1;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [DWIDTH-1:0] out_data_q;
        logic              out_vld_q;
        logic [DWIDTH-1:0] stg_data;
        logic              stg_vld;

        if (READ_LATENCY == 2) begin : g_lat2
            logic [DWIDTH-1:0] s1_data_q;
            logic              s1_vld_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_data_q <= '0;
                    s1_vld_q  <= 1'b0;
                end else if (ready && clk_en) begin
                    s1_vld_q <= upd[p];
                    if (upd[p]) s1_data_q <= rd[p];
                end
            end
            assign stg_data = s1_data_q;
            assign stg_vld  = s1_vld_q;
        end else begin : g_lat1
            assign stg_data = rd[p];
            assign stg_vld  = upd[p];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                out_data_q <= '0;
                out_vld_q  <= 1'b0;
            end else if (ready) begin
                if (clk_en) begin
                    out_vld_q <= stg_vld;
                    if (stg_vld) out_data_q <= stg_data;
                end else begin
                    out_vld_q <= 1'b0;
                end
            end
        end
    end

    assign data_out_0      = g_port[0].out_data_q;
    assign data_out_1      = g_port[1].out_data_q;
    assign dout_valid_0    = g_port[0].out_vld_q;
    assign dout_valid_1    = g_port[1].out_vld_q;
    assign init_busy       = !ready;
    assign collision_flag  = flag_q;
    assign collision_count = cnt_q;
endmodule

// File: tb/tb_dual_port_bram_be.sv
// Directed bench: two RAM instances share stimulus; A is latency 1 (WF/RF, port 0 priority),
// B is latency 2 (NO_CHANGE/WF, port 1 priority).
module tb_dual_port_bram_be;
    logic        clk;
    logic        rst, clk_en, pe0, pe1;
    logic [3:0]  be0, be1;
    logic [9:0]  a0, a1;
    logic [31:0] d0, d1;

    logic [31:0] a_do0, a_do1, b_do0, b_do1;
    logic        a_v0, a_v1, b_v0, b_v1, a_busy, b_busy, a_flag, b_flag;
    logic [15:0] a_cnt, b_cnt;

    int n_checks = 0;
    int n_errors = 0;

    dual_port_bram_be #(
        .DWIDTH(32), .BYTE_W(8), .DEPTH(1024), .READ_LATENCY(1),
        .RDW_MODE_0(1), .RDW_MODE_1(0), .COLL_PRIORITY(0)
    ) u_a (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .port_en_0(pe0), .port_en_1(pe1), .wr_be_0(be0), .wr_be_1(be1),
        .addr_in_0(a0), .addr_in_1(a1), .data_in_0(d0), .data_in_1(d1),
        .data_out_0(a_do0), .data_out_1(a_do1), .dout_valid_0(a_v0), .dout_valid_1(a_v1),
        .init_busy(a_busy), .collision_flag(a_flag), .collision_count(a_cnt)
    );

    dual_port_bram_be #(
        .DWIDTH(32), .BYTE_W(8), .DEPTH(1024), .READ_LATENCY(2),
        .RDW_MODE_0(2), .RDW_MODE_1(1), .COLL_PRIORITY(1)
    ) u_b (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .port_en_0(pe0), .port_en_1(pe1), .wr_be_0(be0), .wr_be_1(be1),
        .addr_in_0(a0), .addr_in_1(a1), .data_in_0(d0), .data_in_1(d1),
        .data_out_0(b_do0), .data_out_1(b_do1), .dout_valid_0(b_v0), .dout_valid_1(b_v1),
        .init_busy(b_busy), .collision_flag(b_flag), .collision_count(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        pe0 = 1'b0; pe1 = 1'b0; be0 = 4'h0; be1 = 4'h0;
    endtask

    task automatic op0(input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
        pe0 = 1'b1; a0 = a; be0 = be; d0 = d;
    endtask

    task automatic op1(input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
        pe1 = 1'b1; a1 = a; be1 = be; d1 = d;
    endtask

    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (a_busy && n < 2000);
        chk(tag, n, 1024);
        chk({tag, "_b"}, 32'(b_busy), 0);
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b1;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        idle();
        tick(); tick();
        chk("rst_busy_a", 32'(a_busy), 1);
        chk("rst_busy_b", 32'(b_busy), 1);
        chk("rst_dout_a0", a_do0, 0);
        chk("rst_vld_b1", 32'(b_v1), 0);
        chk("rst_cnt_a", 32'(a_cnt), 0);
        chk("rst_flag_b", 32'(b_flag), 0);

        rst = 1'b0;
        wait_clear("clear_len0");

        // preload so the clear has something to erase
        op0(10'd5, 4'hF, 32'hDEADBEEF); op1(10'd1023, 4'hF, 32'h12345678); tick();
        op0(10'd5, 4'h0, 32'h0); op1(10'd1023, 4'h0, 32'h0); tick(); idle();
        chk("preload_a0", a_do0, 32'hDEADBEEF);
        chk("preload_a1", a_do1, 32'h12345678);

        rst = 1'b1; tick(); rst = 1'b0;
        chk("clr_dout_a0", a_do0, 0);
        op0(10'd5, 4'hF, 32'hFFFFFFFF); op1(10'd5, 4'hF, 32'hFFFFFFFF);
        repeat (100) tick();
        chk("clr_busy_mid", 32'(a_busy), 1);
        chk("clr_vld_a0", 32'(a_v0), 0);
        rst = 1'b1; tick(); rst = 1'b0;
        wait_clear("clear_len1");
        idle();
        chk("clr_cnt_a", 32'(a_cnt), 0);
        chk("clr_cnt_b", 32'(b_cnt), 0);

        op0(10'd5, 4'h0, 32'h0); op1(10'd1023, 4'h0, 32'h0); tick(); idle();
        chk("clr_rd5_a", a_do0, 0);
        chk("clr_rd5_va", 32'(a_v0), 1);
        chk("clr_rd1023_a", a_do1, 0);
        chk("clr_rd1023_va", 32'(a_v1), 1);
        tick();
        chk("clr_rd5_b", b_do0, 0);
        chk("clr_rd5_vb", 32'(b_v0), 1);
        chk("clr_rd1023_b", b_do1, 0);

        // byte lanes
        op0(10'd7, 4'hF, 32'h11223344); tick();
        op0(10'd7, 4'b0101, 32'hAABBCCDD); tick();
        op0(10'd7, 4'h0, 32'h0); op1(10'd7, 4'h0, 32'h0); tick(); idle();
        chk("be_a1", a_do1, 32'h11BB33DD);
        chk("be_va1", 32'(a_v1), 1);
        chk("be_vb1_early", 32'(b_v1), 0);
        tick();
        chk("be_b1", b_do1, 32'h11BB33DD);
        chk("be_vb1", 32'(b_v1), 1);
        chk("be_b0", b_do0, 32'h11BB33DD);
        chk("be_va1_drop", 32'(a_v1), 0);

        // read-during-write modes
        op0(10'd3, 4'hF, 32'hCAFE0000); tick();
        op0(10'd3, 4'b0011, 32'h0000BEEF); tick();
        chk("rdw_wf_a0", a_do0, 32'hCAFEBEEF);
        chk("rdw_wf_va0", 32'(a_v0), 1);
        chk("rdw_nc_vb0", 32'(b_v0), 0);
        chk("rdw_nc_b0", b_do0, 32'h11BB33DD);
        op0(10'd3, 4'hF, 32'hCAFE0000); tick();
        chk("rdw_nc_vb0b", 32'(b_v0), 0);
        chk("rdw_nc_b0b", b_do0, 32'h11BB33DD);
        idle(); op1(10'd3, 4'b0011, 32'h0000BEEF); tick(); idle();
        chk("rdw_rf_a1", a_do1, 32'hCAFE0000);
        chk("rdw_rf_va1", 32'(a_v1), 1);
        tick();
        chk("rdw_wf_b1", b_do1, 32'hCAFEBEEF);
        chk("rdw_wf_vb1", 32'(b_v1), 1);

        // write-write collision
        op0(10'd9, 4'hF, 32'h5A5A5A5A); tick();
        op0(10'd9, 4'b0011, 32'h01010101); op1(10'd9, 4'b0110, 32'h02020202); tick(); idle();
        chk("ww_flag_a", 32'(a_flag), 1);
        chk("ww_flag_b", 32'(b_flag), 1);
        chk("ww_cnt_a", 32'(a_cnt), 1);
        chk("ww_cnt_b", 32'(b_cnt), 1);
        chk("ww_wf_a0", a_do0, 32'h5A020101);
        chk("ww_rf_a1", a_do1, 32'h5A5A5A5A);
        op0(10'd9, 4'h0, 32'h0); op1(10'd9, 4'h0, 32'h0); tick(); idle();
        chk("ww_flag_drop", 32'(a_flag), 0);
        chk("ww_rd_a0", a_do0, 32'h5A020101);
        chk("ww_wf_b1", b_do1, 32'h5A020201);
        tick();
        chk("ww_rd_b0", b_do0, 32'h5A020201);
        chk("ww_cnt_hold", 32'(a_cnt), 1);

        // read-write collision, then saturate the counter
        op0(10'd4, 4'hF, 32'h44444444); tick();
        op1(10'd4, 4'hF, 32'h99999999); op0(10'd4, 4'h0, 32'h0); tick();
        chk("rw_rd_a0", a_do0, 32'h44444444);
        chk("rw_rf_a1", a_do1, 32'h44444444);
        chk("rw_cnt_a", 32'(a_cnt), 2);
        tick();
        chk("rw_rd_b0", b_do0, 32'h44444444);
        chk("rw_wf_b1", b_do1, 32'h99999999);
        chk("rw_rd_a0_new", a_do0, 32'h99999999);
        repeat (65531) @(posedge clk);
        @(negedge clk);
        chk("sat_fffe_a", 32'(a_cnt), 32'hFFFE);
        chk("sat_fffe_b", 32'(b_cnt), 32'hFFFE);
        tick();
        chk("sat_ffff_a", 32'(a_cnt), 32'hFFFF);
        tick();
        chk("sat_hold_a", 32'(a_cnt), 32'hFFFF);
        chk("sat_hold_b", 32'(b_cnt), 32'hFFFF);
        chk("sat_flag_a", 32'(a_flag), 1);
        idle(); tick();
        chk("sat_flag_drop", 32'(a_flag), 0);

        // clk_en stall with a write request held during the stall
        op1(10'd7, 4'h0, 32'h0); tick();
        chk("stall_a1", a_do1, 32'h11BB33DD);
        chk("stall_vb1_n", 32'(b_v1), 0);
        clk_en = 1'b0; pe1 = 1'b0; op0(10'd7, 4'hF, 32'h00000000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall_vb1_%0d", i), 32'(b_v1), 0);
            chk($sformatf("stall_va1_%0d", i), 32'(a_v1), 0);
            chk($sformatf("stall_b1_%0d", i), b_do1, 32'h99999999);
        end
        clk_en = 1'b1; idle(); tick();
        chk("stall_vb1", 32'(b_v1), 1);
        chk("stall_b1", b_do1, 32'h11BB33DD);
        op0(10'd7, 4'h0, 32'h0); tick(); idle();
        chk("stall_mem_a", a_do0, 32'h11BB33DD);
        chk("stall_cnt", 32'(a_cnt), 32'hFFFF);
        tick();
        chk("stall_mem_b", b_do0, 32'h11BB33DD);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
